// File: rtl/bus_demux_pkg.sv
// -----------------------------------------------------------------------------
// bus_demux_pkg -- shared definitions for the bus_demux block.
//
// Holds the default data word width (`DATA_WIDTH, overridable from the build)
// and the one-entry slot state encoding used by demux_slot.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package bus_demux_pkg;

  // Slot occupancy: EMPTY holds nothing deliverable, FULL presents a word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot -- one-entry output slot of bus_demux.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (slot EMPTY, data 0)
//   wr_en     write strobe; captures wr_data and makes the slot FULL
//   wr_data   word to capture
//   rd_ready  consumer acceptance; drains a FULL slot
//   valid     1 while the slot is FULL
//   data      held word (retains its last value while EMPTY)
//
// A write in the same cycle as a drain keeps the slot FULL with the new word,
// so a continuously fed channel runs without bubbles.
// -----------------------------------------------------------------------------
module demux_slot
  import bus_demux_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  slot_state_t state;
  slot_state_t state_next;
  logic        drain;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: this is a single register, not a memory array; it is reset because
  // the held word must read as 0 while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (wr_en) begin
      data <= wr_data;
    end
  end

  // Next-state logic: a write always wins, a drain alone empties the slot.
  // NOTE: every signal gets its default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    drain      = (state == FULL) && rd_ready;
    state_next = state;
    if (wr_en) begin
      state_next = FULL;
    end else if (drain) begin
      state_next = EMPTY;
    end
  end

  // Output logic.
  always_comb begin
    valid = (state == FULL);
  end

endmodule

// File: rtl/bus_demux.sv
// -----------------------------------------------------------------------------
// bus_demux -- routes one valid/ready source stream to SIZE one-entry
// destination slots selected by in_sel.
//
// Parameters:
//   DATA_WIDTH  width of one data word (default `DATA_WIDTH)
//   SIZE        number of channels; must be a power of two and >= 2
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; empties every slot
//   in_data    source word
//   in_sel     destination channel index
//   in_valid   source word valid
//   in_bcast   (BUS_DEMUX_BROADCAST_EN only) write the word to all slots
//   in_ready   the word is accepted this cycle
//   data_out   flattened channel data, channel N at [N*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  per-channel FULL flags
//   out_ready  per-channel consumer acceptance
//
// Build option: define BUS_DEMUX_BROADCAST_EN to add the in_bcast input.
// in_ready depends only on the selected channel (or on all channels while
// broadcasting), so a stalled channel never blocks traffic to the others.
// -----------------------------------------------------------------------------
module bus_demux
  import bus_demux_pkg::*;
#(
  parameter  int DATA_WIDTH = `DATA_WIDTH,
  parameter  int SIZE       = 4,
  localparam int SEL_WIDTH  = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [SEL_WIDTH-1:0]       in_sel,
  input  logic                       in_valid,
`ifdef BUS_DEMUX_BROADCAST_EN
  input  logic                       in_bcast,
`endif
  output logic                       in_ready,
  output logic [SIZE*DATA_WIDTH-1:0] data_out,
  output logic [SIZE-1:0]            out_valid,
  input  logic [SIZE-1:0]            out_ready
);

  logic [SIZE-1:0] wr_sel;     // one-hot decode of in_sel
  logic [SIZE-1:0] wr_target;  // slots the current word would be written to
  logic [SIZE-1:0] wr_en;
  logic            accept;

  always_comb begin
    wr_sel         = '0;
    wr_sel[in_sel] = 1'b1;
  end

`ifdef BUS_DEMUX_BROADCAST_EN
  // A broadcast needs room in every slot; a slot draining this cycle counts
  // as room because its write and drain happen on the same edge.
  always_comb begin
    if (in_bcast) begin
      in_ready  = &(~out_valid | out_ready);
      wr_target = '1;
    end else begin
      in_ready  = ~out_valid[in_sel] | out_ready[in_sel];
      wr_target = wr_sel;
    end
  end
`else
  always_comb begin
    in_ready  = ~out_valid[in_sel] | out_ready[in_sel];
    wr_target = wr_sel;
  end
`endif

  assign accept = in_valid & in_ready;
  assign wr_en  = {SIZE{accept}} & wr_target;

  for (genvar n = 0; n < SIZE; n++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[n]),
      .wr_data  (in_data),
      .rd_ready (out_ready[n]),
      .valid    (out_valid[n]),
      .data     (data_out[n*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_bus_demux.sv
// -----------------------------------------------------------------------------
// tb_bus_demux -- self-checking bench for bus_demux (SIZE=4, DATA_WIDTH=8).
//
// The driver changes inputs on the falling edge and, 1 ns later, pushes every
// accepted word into a per-channel expectation queue. A separate monitor looks
// 2 ns after the falling edge for channels that will drain on the next rising
// edge and compares the presented word with the queue head.
// Define BUS_DEMUX_BROADCAST_EN to also exercise the broadcast input.
// -----------------------------------------------------------------------------
module tb_bus_demux;

  localparam int DW   = 8;
  localparam int SIZE = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic [1:0]        in_sel = '0;
  logic              in_valid = 1'b0;
  logic              in_bcast = 1'b0;
  logic              in_ready;
  logic [SIZE*DW-1:0] data_out;
  logic [SIZE-1:0]   out_valid;
  logic [SIZE-1:0]   out_ready = '0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [SIZE][$];
  int            drain_cnt [SIZE];
  logic          model_ready;
  logic [SIZE-1:0] model_valid;

  always #5 clk = ~clk;

  bus_demux #(
    .DATA_WIDTH (DW),
    .SIZE       (SIZE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
`ifdef BUS_DEMUX_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] chan(input int n);
    return data_out[n*DW +: DW];
  endfunction

  // Apply inputs now, then record the expected slot view and any accepted word.
  task automatic drive_now(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                           input logic [SIZE-1:0] ordy, input logic b);
    logic all_room;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    in_bcast  = b;
    #1;
    all_room = 1'b1;
    for (int n = 0; n < SIZE; n++) begin
      model_valid[n] = (exp_q[n].size() != 0);
      if (model_valid[n] && !ordy[n]) all_room = 1'b0;
    end
    model_ready = b ? all_room : (!model_valid[s] || ordy[s]);
    if (v && in_ready && !reset) begin
      if (b) begin
        for (int n = 0; n < SIZE; n++) exp_q[n].push_back(d);
      end else begin
        exp_q[s].push_back(d);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d,
                       input logic [SIZE-1:0] ordy, input logic b);
    @(negedge clk);
    drive_now(v, s, d, ordy, b);
  endtask

  // Monitor: every channel about to drain must present its queue head.
  always @(negedge clk) begin
    #2;
    for (int n = 0; n < SIZE; n++) begin
      if (!reset && out_valid[n] && out_ready[n]) begin
        drain_cnt[n]++;
        if (exp_q[n].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drain_ch%0d: got unexpected word %0h expected none", n, chan(n));
        end else begin
          check($sformatf("drain_ch%0d", n), chan(n), exp_q[n].pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base0;
    int pending;
    for (int n = 0; n < SIZE; n++) drain_cnt[n] = 0;

    // Reset state.
    #3;
    check("reset_out_valid", out_valid, 4'b0000);
    check("reset_data_out", data_out, 32'h0);
    check("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Single write to channel 2, then a second write sees the slot full.
    drive(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0);
    check("write_ch2_ready", in_ready, 1'b1);
    drive(1'b1, 2'd2, 8'h33, 4'b0000, 1'b0);
    check("write_ch2_valid", out_valid, 4'b0100);
    check("write_ch2_data", chan(2), 8'hA5);
    check("second_write_ch2_ready", in_ready, 1'b0);

    // Independence: channel 1 stalled, channel 3 still accepts.
    drive(1'b1, 2'd1, 8'h77, 4'b0000, 1'b0);
    drive(1'b1, 2'd3, 8'h99, 4'b0000, 1'b0);
    check("indep_ch3_ready", in_ready, 1'b1);
    drive(1'b0, 2'd1, 8'hFF, 4'b0000, 1'b0);
    check("indep_valid", out_valid, 4'b1110);
    check("indep_ch1_data", chan(1), 8'h77);
    check("indep_ch3_data", chan(3), 8'h99);
    check("stalled_ch1_ready", in_ready, 1'b0);

    // in_data/in_sel ignored while in_valid is 0.
    drive(1'b0, 2'd0, 8'hEE, 4'b0000, 1'b0);
    drive(1'b0, 2'd0, 8'hEE, 4'b0000, 1'b0);
    check("idle_valid", out_valid, 4'b1110);

    // Simultaneous drain and write on channel 0.
    base0 = drain_cnt[0];
    drive(1'b1, 2'd0, 8'h11, 4'b0000, 1'b0);
    drive(1'b1, 2'd0, 8'h22, 4'b0001, 1'b0);
    check("drain_write_ready", in_ready, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
    check("drain_write_valid0", out_valid[0], 1'b1);
    check("drain_write_data0", chan(0), 8'h22);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("drain_write_empty0", out_valid[0], 1'b0);
    check("drain_count_ch0", drain_cnt[0] - base0, 2);

    // Drain everything; channels 1..3 drain in the same cycle.
    drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("drain_all_valid", out_valid, 4'b0000);

`ifdef BUS_DEMUX_BROADCAST_EN
    // Broadcast blocked by stalled channel 2, accepted once it drains.
    drive(1'b1, 2'd2, 8'h66, 4'b0000, 1'b0);
    drive(1'b1, 2'd1, 8'h5A, 4'b0000, 1'b1);
    check("bcast_blocked_ready", in_ready, 1'b0);
    drive(1'b1, 2'd1, 8'h5A, 4'b0100, 1'b1);
    check("bcast_ready", in_ready, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("bcast_valid", out_valid, 4'b1111);
    for (int n = 0; n < SIZE; n++) check($sformatf("bcast_data_ch%0d", n), chan(n), 8'h5A);
    drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("bcast_drained", out_valid, 4'b0000);
`endif

    // Backpressure stress with random select, data and consumer readiness.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom), 1'b0);
      check("stress_in_ready", in_ready, model_ready);
      check("stress_out_valid", out_valid, model_valid);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    pending = 0;
    for (int n = 0; n < SIZE; n++) pending += exp_q[n].size();
    check("stress_no_loss", pending, 0);
    check("stress_drained", out_valid, 4'b0000);

    // Reset mid-operation with slots 1 and 3 full.
    drive(1'b1, 2'd1, 8'hB1, 4'b0000, 1'b0);
    drive(1'b1, 2'd3, 8'hB3, 4'b0000, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("pre_reset_valid", out_valid, 4'b1010);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", out_valid, 4'b0000);
    check("async_reset_data", data_out, 32'h0);
    check("async_reset_ready", in_ready, 1'b1);
    for (int n = 0; n < SIZE; n++) exp_q[n].delete();

    // No write while reset is held, even with in_valid high.
    drive(1'b1, 2'd2, 8'hEE, 4'b0000, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("no_write_in_reset", out_valid, 4'b0000);

    // First write on the first rising edge after release.
    @(negedge clk);
    reset = 1'b0;
    drive_now(1'b1, 2'd0, 8'h44, 4'b0000, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("post_reset_valid", out_valid, 4'b0001);
    check("post_reset_data0", chan(0), 8'h44);
    check("post_reset_data1", chan(1), 8'h00);
    drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    check("final_empty", out_valid, 4'b0000);
    check("final_queue_ch0", exp_q[0].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
